motor_cmd_sequencer: RTL and testbench
======================================

MOTOR_CMD_SEQUENCER -- requirements
Module: motor_cmd_sequencer

Interface
REQ-001 Parameter DWELL_CYCLES, default 50000, sets the brake dwell inserted between two different drive directions; legal range is ≥1.
REQ-002 Parameter HOLD_CYCLES, default 10000000, sets the drive hold time after the last accepted command; legal range is ≥1.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ir_cmd  input  8  one-hot command code: 0x10 brake, 0x02 forward, 0x08 left, 0x20 right, 0x80 backward.
REQ-006 ir_valid  input  1  single-cycle qualifier; ir_cmd SHALL be sampled only when ir_valid=1.
REQ-007 cmd_out  output  8  registered command to the motor direction controller, using the same code set as ir_cmd.
REQ-008 state  output  2  current FSM state: 0 IDLE, 1 DRIVE, 2 DWELL.
REQ-009 busy  output  1  high while in DWELL.
REQ-010 bad_cmd  output  1  one-cycle pulse when a sampled ir_cmd is not one of the five legal codes.

Function
REQ-011 The block SHALL implement a 3-state FSM (IDLE, DRIVE, DWELL) with registered outputs; every cmd_out change SHALL appear one cycle after the triggering sample.
REQ-012 In IDLE, cmd_out SHALL be 0x10; a valid direction SHALL set cmd_out to that direction, load the hold counter and enter DRIVE; a brake command SHALL keep the FSM in IDLE.
REQ-013 In DRIVE, a repeat of the current direction SHALL reload the hold counter with cmd_out unchanged.
REQ-014 In DRIVE, a different direction SHALL store it as pending, set cmd_out to 0x10, load the dwell counter and enter DWELL.
REQ-015 In DRIVE, a brake command SHALL set cmd_out to 0x10 and enter IDLE on the next cycle.
REQ-016 In DRIVE, hold-counter expiry SHALL set cmd_out to 0x10 and enter IDLE, so a direction is output for exactly HOLD_CYCLES cycles after the last accepted matching command.
REQ-017 Dwell timing: cmd_out SHALL be 0x10 for exactly DWELL_CYCLES cycles, then the pending direction with the hold counter loaded, entering DRIVE.
REQ-018 During DWELL, a new direction SHALL overwrite pending without restarting the dwell counter; a brake command SHALL abort to IDLE and discard pending.
REQ-019 A DWELL→DRIVE transition SHALL keep the motor outputs free of any cycle of opposing drive without brake.
REQ-020 Illegal codes, including 0x00 and multi-hot values, SHALL be ignored for the FSM and pulse bad_cmd for one cycle.
REQ-021 Hold expiry and an accepted matching command in the same cycle SHALL resolve as a reload; the FSM SHALL remain in DRIVE.
REQ-022 Counters SHALL be $clog2(max+1) bits wide, count down, and saturate at 0 without wrapping.

Reset
REQ-023 While rst=1, the block SHALL hold state=IDLE, cmd_out=0x10, busy=0, bad_cmd=0, both counters at 0 and pending=0x10, regardless of clk.
REQ-024 Reset asserted mid-DWELL or mid-DRIVE SHALL discard the pending and current command; after deassertion the block SHALL act only on new ir_valid samples.

Configuration
REQ-025 With macro MOTOR_SEQ_HOLD_TIMEOUT_EN defined, the hold counter and REQ-016 SHALL be compiled in.
REQ-026 With MOTOR_SEQ_HOLD_TIMEOUT_EN undefined, the hold counter SHALL be omitted and DRIVE SHALL persist until a brake command, a direction change or reset; all other requirements are unchanged.

Verification (DWELL_CYCLES=4, HOLD_CYCLES=20, MOTOR_SEQ_HOLD_TIMEOUT_EN defined unless stated)
REQ-027 Reset, then forward (0x02) pulse → cmd_out=0x02 one cycle later, held 20 cycles, then 0x10; state goes 1 then 0.
REQ-028 In DRIVE forward, send backward (0x80) → cmd_out=0x10 and busy=1 for exactly 4 cycles, then 0x80, state=1.
REQ-029 During DWELL, send left (0x08) at dwell cycle 2 → dwell still ends after 4 total cycles and cmd_out=0x08; then send brake → IDLE next cycle.
REQ-030 Send ir_cmd=0x03 → bad_cmd pulses one cycle; state and cmd_out unchanged; then repeat forward on the cycle the hold expires → stays in DRIVE with hold reloaded.
REQ-031 Assert rst for 1 cycle mid-DWELL → cmd_out=0x10 immediately; state=0 and pending discarded; with MOTOR_SEQ_HOLD_TIMEOUT_EN undefined, forward held 100 cycles stays 0x02.

Source files
------------

// File: rtl/motor_cmd_sequencer_if.sv
// motor_cmd_sequencer_if: IR command input and motor command/status outputs of the sequencer
interface motor_cmd_sequencer_if;
    logic [7:0] ir_cmd;
    logic       ir_valid;
    logic [7:0] cmd_out;
    logic [1:0] state;
    logic       busy;
    logic       bad_cmd;
    modport master (output ir_cmd, ir_valid, input cmd_out, state, busy, bad_cmd);
    modport slave (input ir_cmd, ir_valid, output cmd_out, state, busy, bad_cmd);
endinterface

// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer: IR command sequencer with brake dwell between directions; MOTOR_SEQ_HOLD_TIMEOUT_EN adds a drive hold timeout
module motor_cmd_sequencer #(
    parameter int DWELL_CYCLES = 50000,
    parameter int HOLD_CYCLES  = 10000000
) (
    input logic clk,
    input logic rst,
    motor_cmd_sequencer_if.slave bus
);
    localparam logic [7:0] BRAKE = 8'h10;
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, DWELL = 2'd2} state_t;
    if (DWELL_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_param
        $error("motor_cmd_sequencer: DWELL_CYCLES and HOLD_CYCLES must be >= 1");
    end
    state_t state_q, state_d;
    logic [7:0] cmd_out_q, cmd_out_d, pend_q, pend_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic bad_cmd_q, bad_cmd_d;
    logic is_brake, is_dir, hold_done;
    assign is_brake  = bus.ir_valid && bus.ir_cmd == BRAKE;
    assign is_dir    = bus.ir_valid && bus.ir_cmd inside {8'h02, 8'h08, 8'h20, 8'h80};
    assign bad_cmd_d = bus.ir_valid && !is_brake && !is_dir;
`ifdef MOTOR_SEQ_HOLD_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    logic [HW-1:0] hold_q, hold_d;
    logic hold_load;
    assign hold_done = hold_q == '0;
    // Loaded on every entry into DRIVE and on each repeat of the driven direction
    assign hold_load = state_d == DRIVE && (state_q != DRIVE || is_dir);
    always_comb begin
        hold_d = hold_load ? HW'(HOLD_CYCLES - 1) : (state_d == DRIVE && !hold_done) ? hold_q - HW'(1) : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_q <= '0;
        else     hold_q <= hold_d;
    end
`else
    assign hold_done = 1'b0;
`endif
    always_comb begin
        state_d   = state_q;
        cmd_out_d = cmd_out_q;
        pend_d    = pend_q;
        dwell_d   = (dwell_q != '0) ? dwell_q - DW'(1) : '0;
        case (state_q)
            IDLE: begin
                if (is_dir) begin
                    state_d   = DRIVE;
                    cmd_out_d = bus.ir_cmd;
                end
            end
            DRIVE: begin
                if (is_brake || (hold_done && !is_dir)) begin
                    state_d   = IDLE;
                    cmd_out_d = BRAKE;
                end else if (is_dir && bus.ir_cmd != cmd_out_q) begin
                    state_d   = DWELL;
                    cmd_out_d = BRAKE;
                    pend_d    = bus.ir_cmd;
                    dwell_d   = DW'(DWELL_CYCLES - 1);
                end
            end
            DWELL: begin
                if (is_brake) begin
                    state_d   = IDLE;
                    cmd_out_d = BRAKE;
                    pend_d    = BRAKE;
                    dwell_d   = '0;
                end else if (dwell_q == '0) begin
                    state_d   = DRIVE;
                    cmd_out_d = is_dir ? bus.ir_cmd : pend_q;
                    pend_d    = BRAKE;
                end else if (is_dir) begin
                    pend_d = bus.ir_cmd;
                end
            end
            default: begin
                state_d   = IDLE;
                cmd_out_d = BRAKE;
                pend_d    = BRAKE;
                dwell_d   = '0;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_out_q <= BRAKE;
            pend_q    <= BRAKE;
            dwell_q   <= '0;
            bad_cmd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_out_q <= cmd_out_d;
            pend_q    <= pend_d;
            dwell_q   <= dwell_d;
            bad_cmd_q <= bad_cmd_d;
        end
    end
    assign bus.cmd_out = cmd_out_q;
    assign bus.state   = state_q;
    assign bus.busy    = state_q == DWELL;
    assign bus.bad_cmd = bad_cmd_q;
endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// tb_motor_cmd_sequencer: deadline-based reference model plus directed scenarios for motor_cmd_sequencer
module tb_motor_cmd_sequencer;
    localparam int DWELL = 4;
    localparam int HOLD  = 20;
`ifdef MOTOR_SEQ_HOLD_TIMEOUT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif
    localparam logic [7:0] BRK = 8'h10;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    motor_cmd_sequencer_if bus();
    motor_cmd_sequencer #(.DWELL_CYCLES(DWELL), .HOLD_CYCLES(HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic bit legal(input logic [7:0] c);
        return $onehot(c) && (c & 8'hBA) != 8'h00;
    endfunction
    function automatic bit dir(input logic [7:0] c);
        return legal(c) && c != BRK;
    endfunction
    // Model tracks absolute cycle deadlines instead of countdown counters
    logic [1:0] m_st;
    logic [7:0] m_cmd, m_pend;
    logic m_bad;
    int m_exp, m_dend;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st <= 2'd0; m_cmd <= BRK; m_pend <= BRK; m_bad <= 1'b0;
        end else begin
            m_bad <= bus.ir_valid && !legal(bus.ir_cmd);
            case (m_st)
                2'd0: if (bus.ir_valid && dir(bus.ir_cmd)) begin
                    m_st <= 2'd1; m_cmd <= bus.ir_cmd; m_exp <= cyc + HOLD;
                end
                2'd1: if (bus.ir_valid && bus.ir_cmd == BRK) begin
                    m_st <= 2'd0; m_cmd <= BRK;
                end else if (bus.ir_valid && bus.ir_cmd == m_cmd) begin
                    m_exp <= cyc + HOLD;
                end else if (bus.ir_valid && dir(bus.ir_cmd)) begin
                    m_st <= 2'd2; m_cmd <= BRK; m_pend <= bus.ir_cmd; m_dend <= cyc + DWELL;
                end else if (HOLD_EN && cyc >= m_exp) begin
                    m_st <= 2'd0; m_cmd <= BRK;
                end
                default: if (bus.ir_valid && bus.ir_cmd == BRK) begin
                    m_st <= 2'd0; m_cmd <= BRK; m_pend <= BRK;
                end else if (cyc >= m_dend) begin
                    m_st <= 2'd1; m_cmd <= (bus.ir_valid && dir(bus.ir_cmd)) ? bus.ir_cmd : m_pend;
                    m_exp <= cyc + HOLD;
                end else if (bus.ir_valid && dir(bus.ir_cmd)) begin
                    m_pend <= bus.ir_cmd;
                end
            endcase
        end
    end
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        chk("model cmd_out", bus.cmd_out, m_cmd);
        chk("model state", {6'd0, bus.state}, {6'd0, m_st});
        chk("model busy", {7'd0, bus.busy}, {7'd0, m_st == 2'd2});
        chk("model bad_cmd", {7'd0, bus.bad_cmd}, {7'd0, m_bad});
    end
    task automatic lit(input string nm, input logic [7:0] c, input logic [1:0] s, input logic b);
        chk({nm, " cmd_out"}, bus.cmd_out, c);
        chk({nm, " state"}, {6'd0, bus.state}, {6'd0, s});
        chk({nm, " busy"}, {7'd0, bus.busy}, {7'd0, b});
    endtask
    task automatic send(input logic [7:0] c);
        bus.ir_cmd = c;
        bus.ir_valid = 1'b1;
        @(negedge clk);
        bus.ir_valid = 1'b0;
        bus.ir_cmd = 8'h00;
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.ir_valid = 1'b0;
        bus.ir_cmd = 8'h00;
        #1 rst = 1'b1;
        idle(2);
        lit("reset", BRK, 2'd0, 1'b0);
        chk("reset bad_cmd", {7'd0, bus.bad_cmd}, 8'h00);
        rst = 1'b0;
        send(8'h02);
        lit("fwd start", 8'h02, 2'd1, 1'b0);
        idle(19);
        lit("fwd last hold cycle", 8'h02, 2'd1, 1'b0);
        idle(1);
        lit("fwd hold expiry", HOLD_EN ? BRK : 8'h02, HOLD_EN ? 2'd0 : 2'd1, 1'b0);
        send(BRK);
        lit("brake to idle", BRK, 2'd0, 1'b0);
        send(BRK);
        lit("brake in idle", BRK, 2'd0, 1'b0);
        send(8'h02);
        send(8'h80);
        lit("dwell first", BRK, 2'd2, 1'b1);
        idle(3);
        lit("dwell fourth", BRK, 2'd2, 1'b1);
        idle(1);
        lit("dwell end back", 8'h80, 2'd1, 1'b0);
        send(8'h02);
        send(8'h08);
        lit("dwell overwrite", BRK, 2'd2, 1'b1);
        idle(2);
        lit("dwell overwrite last", BRK, 2'd2, 1'b1);
        idle(1);
        lit("dwell end left", 8'h08, 2'd1, 1'b0);
        send(BRK);
        lit("left brake", BRK, 2'd0, 1'b0);
        send(8'h02);
        send(8'h03);
        lit("multi-hot ignored", 8'h02, 2'd1, 1'b0);
        chk("multi-hot bad_cmd", {7'd0, bus.bad_cmd}, 8'h01);
        idle(1);
        chk("bad_cmd one cycle", {7'd0, bus.bad_cmd}, 8'h00);
        idle(17);
        send(8'h02);
        lit("reload at expiry", 8'h02, 2'd1, 1'b0);
        idle(19);
        lit("reloaded hold last", 8'h02, 2'd1, 1'b0);
        idle(1);
        lit("reloaded hold expiry", HOLD_EN ? BRK : 8'h02, HOLD_EN ? 2'd0 : 2'd1, 1'b0);
        send(BRK);
        send(8'h00);
        chk("zero bad_cmd", {7'd0, bus.bad_cmd}, 8'h01);
        lit("zero ignored", BRK, 2'd0, 1'b0);
        send(8'h02);
        send(8'h20);
        idle(1);
        rst = 1'b1;
        #1;
        lit("async reset", BRK, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        lit("pending discarded", BRK, 2'd0, 1'b0);
        send(8'h02);
        idle(99);
        lit("fwd 100 cycles", HOLD_EN ? BRK : 8'h02, HOLD_EN ? 2'd0 : 2'd1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
